// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Loads a program into the RV32I instruction memory from a host byte stream.
//   The stream is a 4-byte little-endian word count N followed by N
//   little-endian 32-bit instruction words. Each assembled word is written to
//   the instruction memory one cycle after its last byte is accepted. The core
//   is held in reset while a load is in progress or after a rejected length.
//   It is released on a successful completion, so fetch restarts from address 0.
//
// Parameters
//   XLEN   data/address width of the instruction-memory port (4 bytes per word)
//   DEPTH  instruction-memory depth in words; largest accepted word count
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_valid  in   byte_data valid this cycle
//   byte_data   in   stream byte
//   byte_ready  out  loader accepts a byte this cycle
//   mem_we      out  instruction-memory write enable, one pulse per word
//   mem_waddr   out  word-aligned byte address of the write
//   mem_wdata   out  assembled instruction word
//   core_hold   out  1 = keep the core in reset
//   busy        out  1 while receiving the length or the data words
//   done        out  load completed successfully (level)
//   err         out  length rejected (level)
//   word_count  out  words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            core_hold,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  logic [1:0]      r_bcnt;
  logic [XLEN-1:0] r_asm;
  logic [XLEN-1:0] r_len;
  logic [XLEN-1:0] r_widx;

  logic            r_byte_ready;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_waddr;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_core_hold;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [XLEN-1:0] r_word_count;

  logic            w_xfer;
  logic            w_last_byte;
  logic [XLEN-1:0] w_full;
  logic [XLEN-1:0] w_widx_nxt;
  logic            w_last_word;

  assign w_xfer      = byte_valid & r_byte_ready;
  assign w_last_byte = (r_bcnt == 2'd3);
  assign w_widx_nxt  = r_widx + XLEN'(1);
  assign w_last_word = (w_widx_nxt == r_len);

  // Word including the byte being accepted now; the length field and the
  // instruction words share this assembly path.
  always_comb begin
    w_full = r_asm;
    w_full[{r_bcnt, 3'b000} +: 8] = byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bcnt       <= 2'd0;
      r_asm        <= '0;
      r_len        <= '0;
      r_widx       <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_core_hold  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state      <= S_LEN;
            r_bcnt       <= 2'd0;
            r_asm        <= '0;
            r_len        <= '0;
            r_widx       <= '0;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_core_hold  <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
          end
        end

        S_LEN: begin
          if (w_xfer) begin
            r_bcnt <= r_bcnt + 2'd1;
            r_asm  <= w_full;
            if (w_last_byte) begin
              r_asm <= '0;
              r_len <= w_full;
              if (w_full == '0) begin
                r_state      <= S_DONE;
                r_byte_ready <= 1'b0;
                r_busy       <= 1'b0;
                r_core_hold  <= 1'b0;
                r_done       <= 1'b1;
              end else if (w_full > XLEN'(DEPTH)) begin
                r_state      <= S_ERR;
                r_byte_ready <= 1'b0;
                r_busy       <= 1'b0;
                r_err        <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            r_bcnt <= r_bcnt + 2'd1;
            r_asm  <= w_full;
            if (w_last_byte) begin
              // Write lands in the cycle after the accepting edge; the next
              // word's first byte may be accepted in that same cycle.
              r_asm        <= '0;
              r_mem_we     <= 1'b1;
              r_mem_waddr  <= {r_widx[XLEN-3:0], 2'b00};
              r_mem_wdata  <= w_full;
              r_word_count <= w_widx_nxt;
              r_widx       <= w_widx_nxt;
              if (w_last_word) begin
                r_state      <= S_DONE;
                r_byte_ready <= 1'b0;
                r_busy       <= 1'b0;
                r_core_hold  <= 1'b0;
                r_done       <= 1'b1;
              end
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_core_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_we     = r_mem_we;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;
  assign core_hold  = r_core_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule
